// File: rtl/net_bus_pkg.sv
// rtl/net_bus_pkg.sv - NetBus flit layout constants shared by the flit FIFO and its consumers
package net_bus_pkg;

    // Flit layout: [0] EOF, [13:1] ROUTE, then 9-bit lanes {valid, byte}
    localparam int FLIT_EOF_BIT = 0;
    localparam int ROUTE_LSB    = 1;
    localparam int ROUTE_W      = 13;
    localparam int LANE_BASE    = 14;
    localparam int LANE_W       = 9;

    function automatic int flit_width(input int data_width);
        return data_width * LANE_W + LANE_BASE;
    endfunction

endpackage

// File: rtl/net_bus_lane_pick.sv
// rtl/net_bus_lane_pick.sv - lowest-set-bit encoder over a lane mask
//
// Ports:
//   i_mask    lane mask to scan
//   o_idx     index of the lowest set bit (0 when the mask is empty)
//   o_onehot  one-hot of the lowest set bit (all zero when the mask is empty)
//   o_last    the lowest set bit is the only set bit
module net_bus_lane_pick #(
    parameter int DATA_WIDTH = 4,
    parameter int IDX_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
    input  logic [DATA_WIDTH-1:0] i_mask,
    output logic [IDX_W-1:0]      o_idx,
    output logic [DATA_WIDTH-1:0] o_onehot,
    output logic                  o_last
);

    // Scan from the top down so the lowest set bit is the final winner
    always_comb begin
        o_idx    = '0;
        o_onehot = '0;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            if (i_mask[i]) begin
                o_idx       = IDX_W'(i);
                o_onehot    = '0;
                o_onehot[i] = 1'b1;
            end
        end
    end

    assign o_last = (|i_mask) & ~(|(i_mask & ~o_onehot));

endmodule

// File: rtl/net_bus_frame_serializer.sv
// rtl/net_bus_frame_serializer.sv - NetBus flit FIFO reader emitting a framed byte stream
//
// Ports:
//   CLK, RESETn                 FIFO read clock, async active-low reset
//   IN_DATA/IN_VALID/IN_READY   flit pop interface from the FIFO
//   IN_FRAME                    FIFO holds at least one complete frame
//   OUT_DATA/OUT_VALID/OUT_READY byte stream, with OUT_SOF/OUT_LAST markers
//   OUT_ROUTE                   route tag of the current frame
//   DROP                        pulse when a zero-lane EOF flit closes a frame
//   FRAME_CNT                   completed frame counter (wraps)
module net_bus_frame_serializer
    import net_bus_pkg::*;
#(
    parameter int DATA_WIDTH  = 4,
    parameter int GATE_FRAMES = 1
) (
    input  logic                                CLK,
    input  logic                                RESETn,
    input  logic [flit_width(DATA_WIDTH)-1:0]   IN_DATA,
    input  logic                                IN_VALID,
    output logic                                IN_READY,
    input  logic                                IN_FRAME,
    output logic [7:0]                          OUT_DATA,
    output logic                                OUT_VALID,
    input  logic                                OUT_READY,
    output logic                                OUT_SOF,
    output logic                                OUT_LAST,
    output logic [ROUTE_W-1:0]                  OUT_ROUTE,
    output logic                                DROP,
    output logic [15:0]                         FRAME_CNT
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [DATA_WIDTH*8-1:0] r_lanes;
    logic [DATA_WIDTH-1:0]   r_mask;
    logic                    r_eof;
    logic                    r_in_frame;
    logic                    r_first;
    logic [ROUTE_W-1:0]      r_route;
    logic                    r_drop;
    logic [15:0]             r_frame_cnt;

    logic [DATA_WIDTH-1:0]   w_in_mask;
    logic [DATA_WIDTH*8-1:0] w_in_bytes;
    logic [IDX_W-1:0]        w_idx;
    logic [DATA_WIDTH-1:0]   w_onehot;
    logic                    w_last_lane;
    logic                    w_valid;
    logic                    w_hs;
    logic                    w_flit_done;
    logic                    w_eof_done;
    logic                    w_open;
    logic                    w_gate_ok;
    logic                    w_accept;
    logic                    w_in_eof;
    logic                    w_first_eff;

    always_comb begin
        w_in_mask  = '0;
        w_in_bytes = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            w_in_mask[i]         = IN_DATA[LANE_BASE + LANE_W*i + 8];
            w_in_bytes[8*i +: 8] = IN_DATA[LANE_BASE + LANE_W*i +: 8];
        end
    end

    net_bus_lane_pick #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W)
    ) u_pick (
        .i_mask   (r_mask),
        .o_idx    (w_idx),
        .o_onehot (w_onehot),
        .o_last   (w_last_lane)
    );

    assign w_in_eof    = IN_DATA[FLIT_EOF_BIT];
    assign w_valid     = |r_mask;
    assign w_hs        = w_valid & OUT_READY;
    assign w_flit_done = w_hs & w_last_lane;
    assign w_eof_done  = w_flit_done & r_eof;
    // Frame state as seen by a flit loading on this edge: an EOF byte
    // handshaking now makes the incoming flit the first of a new frame.
    assign w_open      = r_in_frame & ~w_eof_done;
    assign w_gate_ok   = (GATE_FRAMES == 0) | w_open | IN_FRAME;
    assign IN_READY    = RESETn & (~w_valid | w_flit_done) & w_gate_ok;
    assign w_accept    = IN_VALID & IN_READY;
    assign w_first_eff = r_first & ~w_hs;

    assign OUT_VALID = w_valid;
    assign OUT_DATA  = w_valid ? r_lanes[w_idx*8 +: 8] : 8'h00;
    assign OUT_SOF   = w_valid & r_first;
    assign OUT_LAST  = w_valid & r_eof & w_last_lane;
    assign OUT_ROUTE = r_route;
    assign DROP      = r_drop;
    assign FRAME_CNT = r_frame_cnt;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_lanes     <= '0;
            r_mask      <= '0;
            r_eof       <= 1'b0;
            r_in_frame  <= 1'b0;
            r_first     <= 1'b0;
            r_route     <= '0;
            r_drop      <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_drop <= 1'b0;
            if (w_hs) begin
                r_mask  <= r_mask & ~w_onehot;
                r_first <= 1'b0;
            end
            if (w_eof_done) begin
                r_in_frame  <= 1'b0;
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            if (w_accept) begin
                r_mask  <= w_in_mask;
                r_lanes <= w_in_bytes;
                r_eof   <= w_in_eof;
                if ((w_in_mask == '0) && w_in_eof) begin
                    // Empty EOF flit: closes an open frame, or is discarded
                    // outright when it would have started one.
                    if (w_open) begin
                        r_in_frame <= 1'b0;
                        if (!w_first_eff) begin
                            r_drop      <= 1'b1;
                            r_frame_cnt <= r_frame_cnt + 16'd1;
                        end
                    end
                end else if (!w_open) begin
                    r_in_frame <= 1'b1;
                    r_route    <= IN_DATA[ROUTE_LSB +: ROUTE_W];
                    r_first    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_net_bus_frame_serializer.sv
// tb/tb_net_bus_frame_serializer.sv - self-checking bench for net_bus_frame_serializer
module tb_net_bus_frame_serializer;

    logic        CLK = 1'b0;
    logic        RESETn;
    logic [49:0] IN_DATA;
    logic        IN_VALID, IN_READY, IN_FRAME;
    logic [7:0]  OUT_DATA;
    logic        OUT_VALID, OUT_READY, OUT_SOF, OUT_LAST, DROP;
    logic [12:0] OUT_ROUTE;
    logic [15:0] FRAME_CNT;

    logic [49:0] g_in_data;
    logic        g_in_valid, g_in_ready, g_in_frame;
    logic [7:0]  g_out_data;
    logic        g_out_valid, g_out_ready, g_out_sof, g_out_last, g_drop;
    logic [12:0] g_out_route;
    logic [15:0] g_frame_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    logic [22:0] q[$];
    logic        stalled = 1'b0;
    logic [22:0] held;
    logic [22:0] cur;
    logic [22:0] exp_b;
    int          exp_cnt = 0;

    always #5 CLK = ~CLK;

    net_bus_frame_serializer #(.DATA_WIDTH(4), .GATE_FRAMES(1)) dut (
        .CLK(CLK), .RESETn(RESETn), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID),
        .IN_READY(IN_READY), .IN_FRAME(IN_FRAME), .OUT_DATA(OUT_DATA),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_SOF(OUT_SOF),
        .OUT_LAST(OUT_LAST), .OUT_ROUTE(OUT_ROUTE), .DROP(DROP), .FRAME_CNT(FRAME_CNT)
    );

    net_bus_frame_serializer #(.DATA_WIDTH(4), .GATE_FRAMES(0)) dut_ct (
        .CLK(CLK), .RESETn(RESETn), .IN_DATA(g_in_data), .IN_VALID(g_in_valid),
        .IN_READY(g_in_ready), .IN_FRAME(g_in_frame), .OUT_DATA(g_out_data),
        .OUT_VALID(g_out_valid), .OUT_READY(g_out_ready), .OUT_SOF(g_out_sof),
        .OUT_LAST(g_out_last), .OUT_ROUTE(g_out_route), .DROP(g_drop), .FRAME_CNT(g_frame_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [49:0] mk(input logic [12:0] route, input logic eof,
                                       input logic [3:0] m, input logic [31:0] bytes);
        logic [49:0] f;
        f = '0;
        f[0] = eof;
        f[13:1] = route;
        for (int i = 0; i < 4; i++) f[14 + 9*i +: 9] = {m[i], bytes[8*i +: 8]};
        return f;
    endfunction

    // Model: one expected byte per set lane, lane 0 first
    task automatic push_exp(input logic [3:0] m, input logic [31:0] bytes, input logic eof,
                            input logic [12:0] route, input logic first);
        int  last_i;
        logic sof;
        last_i = -1;
        for (int i = 0; i < 4; i++) if (m[i]) last_i = i;
        sof = first;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                q.push_back({bytes[8*i +: 8], sof, (eof && i == last_i), route});
                sof = 1'b0;
            end
        end
        if (eof && last_i >= 0) exp_cnt++;
    endtask

    task automatic wait_accept(input string tag);
        bit got;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge CLK);
            if (IN_VALID && IN_READY) got = 1;
            @(posedge CLK);
            #1;
        end
        if (!got) check(tag, 32'd0, 32'd1);
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Scoreboard and stall-stability monitor
    always @(negedge CLK) begin
        if (!RESETn) begin
            stalled = 1'b0;
        end else begin
            cur = {OUT_DATA, OUT_SOF, OUT_LAST, OUT_ROUTE};
            if (stalled) check("stall_hold", {8'd0, OUT_VALID, cur}, {8'd0, 1'b1, held});
            if (OUT_VALID && OUT_READY) begin
                check("byte_expected", (q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    exp_b = q.pop_front();
                    check("byte", {9'd0, cur}, {9'd0, exp_b});
                end
            end
            stalled = OUT_VALID && !OUT_READY;
            held    = cur;
        end
    end

    initial begin
        int cnt;
        logic [5:0] vv;
        logic [1:0] rv;
        int cnt_before;

        RESETn = 1'b0;
        IN_DATA = mk(13'h0A5, 1'b1, 4'hF, 32'h44332211);
        IN_VALID = 1'b1; IN_FRAME = 1'b1; OUT_READY = 1'b1;
        g_in_data = '0; g_in_valid = 1'b0; g_in_frame = 1'b0; g_out_ready = 1'b1;

        // Reset and idle
        repeat (3) @(negedge CLK);
        check("rst_in_ready", IN_READY, 0);
        check("rst_flags", {OUT_VALID, OUT_SOF, OUT_LAST, DROP}, 0);
        check("rst_data_route", {OUT_DATA, OUT_ROUTE}, 0);
        check("rst_frame_cnt", FRAME_CNT, 0);
        @(posedge CLK); #1;
        IN_FRAME = 1'b0;
        RESETn = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (IN_READY) cnt++;
        end
        check("gate_idle_ready", cnt, 0);
        check("idle_out_valid", OUT_VALID, 0);
        @(posedge CLK); #1;

        // Single full flit
        push_exp(4'hF, 32'h44332211, 1'b1, 13'h0A5, 1'b1);
        IN_FRAME = 1'b1;
        wait_accept("accept_full");
        IN_VALID = 1'b0; IN_FRAME = 1'b0;
        vv = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            vv[i] = OUT_VALID;
            if (i == 0) check("full_route", OUT_ROUTE, 13'h0A5);
            @(posedge CLK); #1;
        end
        check("full_valid_run", vv[4:0], 5'b01111);
        check("full_cnt", FRAME_CNT, exp_cnt);

        // Sparse lanes with back-pressure 1,0,1
        IN_DATA = mk(13'h123, 1'b1, 4'b1010, 32'hD000B000);
        push_exp(4'b1010, 32'hD000B000, 1'b1, 13'h123, 1'b1);
        IN_VALID = 1'b1; IN_FRAME = 1'b1;
        wait_accept("accept_sparse");
        IN_VALID = 1'b0;
        OUT_READY = 1'b1;
        cycles(1);
        OUT_READY = 1'b0;
        @(negedge CLK);
        check("sparse_stall_data", {OUT_VALID, OUT_DATA}, {1'b1, 8'hD0});
        @(posedge CLK); #1;
        OUT_READY = 1'b1;
        cycles(2);
        check("sparse_cnt", FRAME_CNT, exp_cnt);
        check("sparse_drained", q.size(), 0);

        // Back-to-back flits
        IN_DATA = mk(13'h055, 1'b0, 4'b0011, 32'h0000A2A1);
        push_exp(4'b0011, 32'h0000A2A1, 1'b0, 13'h055, 1'b1);
        push_exp(4'b0111, 32'h00B3B2B1, 1'b1, 13'h055, 1'b0);
        IN_VALID = 1'b1;
        wait_accept("accept_b2b_a");
        IN_DATA = mk(13'h1FF, 1'b1, 4'b0111, 32'h00B3B2B1);
        vv = '0; rv = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            vv[i] = OUT_VALID;
            if (i < 2) rv[i] = IN_READY;
            @(posedge CLK); #1;
            if (i == 1) IN_VALID = 1'b0;
        end
        check("b2b_ready_pulse", rv, 2'b10);
        check("b2b_valid_run", vv, 6'b011111);
        check("b2b_cnt", FRAME_CNT, exp_cnt);

        // Frame gating at a frame boundary
        IN_DATA = mk(13'h010, 1'b1, 4'b0001, 32'h000000C1);
        push_exp(4'b0001, 32'h000000C1, 1'b1, 13'h010, 1'b1);
        IN_VALID = 1'b1; IN_FRAME = 1'b1;
        wait_accept("accept_gate_a");
        IN_DATA = mk(13'h020, 1'b1, 4'b0001, 32'h000000C2);
        IN_FRAME = 1'b0;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            if (IN_READY) cnt++;
            @(posedge CLK); #1;
        end
        check("gate_hold", cnt, 0);
        push_exp(4'b0001, 32'h000000C2, 1'b1, 13'h020, 1'b1);
        IN_FRAME = 1'b1;
        @(negedge CLK);
        check("gate_release", IN_READY, 1);
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        cycles(3);
        check("gate_cnt", FRAME_CNT, exp_cnt);

        // Cut-through instance: no stall on IN_FRAME=0
        g_in_data = mk(13'h077, 1'b1, 4'b0001, 32'h0000005A);
        g_in_valid = 1'b1;
        @(negedge CLK);
        check("ct_ready_first", g_in_ready, 1);
        @(posedge CLK); #1;
        g_in_data = mk(13'h078, 1'b1, 4'b0001, 32'h0000006B);
        @(negedge CLK);
        check("ct_byte_a", {g_out_valid, g_out_last, g_out_data}, {1'b1, 1'b1, 8'h5A});
        check("ct_ready_boundary", g_in_ready, 1);
        @(posedge CLK); #1;
        g_in_valid = 1'b0;
        @(negedge CLK);
        check("ct_byte_b", {g_out_valid, g_out_sof, g_out_data, g_out_route}, {1'b1, 1'b1, 8'h6B, 13'h078});
        @(posedge CLK); #1;

        // Zero-lane EOF closing a 2-byte frame
        IN_DATA = mk(13'h0EE, 1'b0, 4'b0011, 32'h0000E2E1);
        push_exp(4'b0011, 32'h0000E2E1, 1'b0, 13'h0EE, 1'b1);
        IN_VALID = 1'b1;
        cnt_before = exp_cnt;
        wait_accept("accept_drop_a");
        IN_DATA = mk(13'h000, 1'b1, 4'b0000, 32'h0);
        wait_accept("accept_drop_eof");
        IN_VALID = 1'b0;
        exp_cnt++;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            if (DROP) cnt++;
            @(posedge CLK); #1;
        end
        check("drop_pulses", cnt, 1);
        check("drop_cnt", FRAME_CNT, cnt_before + 1);

        // Zero-lane EOF as a frame's first flit is discarded
        IN_DATA = mk(13'h3AB, 1'b1, 4'b0000, 32'h0);
        IN_VALID = 1'b1;
        wait_accept("accept_discard");
        IN_VALID = 1'b0;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            if (DROP || OUT_VALID) cnt++;
            @(posedge CLK); #1;
        end
        check("discard_quiet", cnt, 0);
        check("discard_cnt", FRAME_CNT, exp_cnt);

        // Reset mid-frame
        OUT_READY = 1'b0;
        IN_DATA = mk(13'h0BB, 1'b1, 4'hF, 32'h04030201);
        IN_VALID = 1'b1;
        wait_accept("accept_reset_frame");
        IN_VALID = 1'b0;
        @(negedge CLK);
        check("pre_reset_valid", OUT_VALID, 1);
        #2;
        RESETn = 1'b0;
        #1;
        check("async_reset_valid", OUT_VALID, 0);
        check("async_reset_cnt", FRAME_CNT, 0);
        q.delete();
        @(posedge CLK);
        @(posedge CLK); #1;
        RESETn = 1'b1;
        OUT_READY = 1'b1;
        @(negedge CLK);
        check("post_reset_flags", {OUT_VALID, OUT_SOF, OUT_LAST, DROP}, 0);
        check("post_reset_route", OUT_ROUTE, 0);
        check("final_queue_empty", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/net_bus_frame_serializer.md
# net_bus_frame_serializer

Read-side consumer of the NetBus asynchronous flit FIFO, running entirely in the FIFO read clock domain. It pops NetBus flits, which carry a 14-bit control field plus DATA_WIDTH 9-bit byte lanes, and emits one byte per cycle on a ready/valid byte stream with start/last markers and a per-frame route tag. When gating is enabled it starts a new frame only after the FIFO reports a complete frame resident (IN_FRAME), so a frame is never stalled mid-stream by a slow writer.

## Interface
- DATA_WIDTH, 4: byte lanes per flit; flit width is DATA_WIDTH*9+14.
- GATE_FRAMES, 1: 1 = a frame's first flit is accepted only while IN_FRAME=1; 0 = cut-through, IN_FRAME ignored.
- CLK  in  1  single clock (FIFO RCLK domain).
- RESETn  in  1  reset; asynchronous assert, active-low.
- IN_DATA  in  DATA_WIDTH*9+14  flit: [0] EOF, [13:1] ROUTE, lane i = [14+9i +: 9] with bit 8 = lane valid and bits 7:0 = byte; lane 0 is sent first.
- IN_VALID  in  1  flit available.
- IN_READY  out  1  flit consumed on IN_VALID&IN_READY.
- IN_FRAME  in  1  at least one complete frame is resident in the FIFO.
- OUT_DATA  out  8  byte.
- OUT_VALID  out  1  byte valid.
- OUT_READY  in  1  byte accepted on OUT_VALID&OUT_READY.
- OUT_SOF  out  1  first byte of frame.
- OUT_LAST  out  1  last byte of frame.
- OUT_ROUTE  out  13  ROUTE of the frame's first flit; held for the whole frame.
- DROP  out  1  one-cycle pulse: a zero-lane EOF flit closed a frame.
- FRAME_CNT  out  16  frames completed (OUT_LAST handshakes plus DROP events); wraps 0xFFFF->0.

## Operation
- State: holding register (flit), remaining lane mask, in_frame flag, first_byte flag.
- Holding register is empty when the mask is zero. IN_READY = empty OR (OUT_VALID & OUT_READY & current lane is the last set lane in the mask), further qualified: if in_frame=0 and GATE_FRAMES=1, IN_READY also requires IN_FRAME=1.
- On flit accept: mask <= lane-valid bits. If in_frame=0: OUT_ROUTE <= ROUTE, first_byte <= 1, in_frame <= 1. A flit with EOF=1 clears in_frame once its last byte handshakes.
- Lane select: lowest set bit of the mask; OUT_DATA = that lane's byte; the bit is cleared on handshake.
- OUT_LAST = EOF & exactly one bit left in the mask. OUT_SOF = first_byte; first_byte clears on the first byte handshake.
- Zero-lane flit, EOF=0: consumed, nothing emitted.
- Zero-lane flit, EOF=1: consumed; if the frame has already sent bytes, DROP pulses, FRAME_CNT increments and in_frame clears. If it is the frame's first flit, it is silently discarded.
- ROUTE bits of non-first flits are ignored.

## Timing
- Reset values: OUT_VALID=0, OUT_SOF=0, OUT_LAST=0, OUT_DATA=0, OUT_ROUTE=0, DROP=0, FRAME_CNT=0, IN_READY=0 while RESETn=0, in_frame=0, mask=0.
- Latency: a flit accepted at edge N presents OUT_VALID in cycle N+1, because all outputs are registered from the holding state.
- Throughput: 1 byte/cycle. A flit with k valid lanes occupies k cycles. The next flit loads on the same edge as the previous flit's last byte, so there is no bubble when IN_VALID=1.
- OUT_VALID never deasserts without a handshake; OUT_DATA, OUT_SOF, OUT_LAST and OUT_ROUTE stay stable while OUT_VALID&!OUT_READY.
- Frame boundary: after an EOF byte handshake, the next flit loads on that same edge only if IN_FRAME=1 in that cycle (gated mode).
- Reset mid-frame: all state clears asynchronously and the partial frame is lost. The upstream FIFO shares RESETn, so no stale flits remain.

## Structure
- The net_bus_pkg package holds FLIT_EOF_BIT=0, ROUTE_LSB=1, ROUTE_W=13, LANE_BASE=14, LANE_W=9 and a flit_width(DATA_WIDTH) function. The FIFO and this block both use it.
- Sub-module net_bus_lane_pick: combinational lowest-set-bit encoder on a DATA_WIDTH mask, outputting index, one-hot and a last-bit flag.

## Test plan
- Reset and idle: hold RESETn low, then release -> all outputs 0. Present IN_VALID=1 with IN_FRAME=0 and GATE_FRAMES=1 -> IN_READY stays 0 indefinitely.
- Single full flit: lanes 0x11,0x22,0x33,0x44 all valid, EOF=1, ROUTE=0x0A5, IN_FRAME=1, OUT_READY=1 -> bytes 11,22,33,44 in 4 consecutive cycles starting one cycle after accept; SOF on 0x11; LAST on 0x44; OUT_ROUTE=0x0A5; FRAME_CNT=1.
- Sparse lanes plus back-pressure: lane mask 1010b carrying 0xB0 and 0xD0, OUT_READY toggling 1,0,1 -> only 0xB0 then 0xD0 are emitted; data stays stable while stalled.
- Back-to-back flits: flit A has 2 lanes with EOF=0, flit B has 3 lanes with EOF=1, IN_VALID held high -> 5 bytes in 5 consecutive cycles; IN_READY pulses on the edge of A's second byte.
- Frame gating: first frame ends with IN_FRAME=0 and the next flit waiting -> no accept until IN_FRAME rises; the accept occurs on that cycle. Repeat with GATE_FRAMES=0 -> accept with no stall.
- Degenerate EOF and reset: a 2-byte frame followed by a zero-lane EOF flit -> DROP pulses once and FRAME_CNT increments by 1. Assert RESETn mid-frame -> OUT_VALID=0 immediately and FRAME_CNT=0.
